// File: rtl/hd_bitop_pipe.sv
// Two-stage bit-manipulation pipe (ABS/CLZ/CTZ/POP/ISO/CLR): 2-cycle latency, 1 op/cycle.
// Full valid/ready backpressure; a stalled stage holds its contents and outputs stay stable.
module hd_bitop_pipe #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_op,
   input  logic [WIDTH-1:0] in_data,
   input  logic [3:0]       in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [3:0]       out_tag,
   output logic             out_flag,
   output logic             busy
);
   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   localparam logic [2:0] OP_ABS = 3'd0;
   localparam logic [2:0] OP_CLZ = 3'd1;
   localparam logic [2:0] OP_CTZ = 3'd2;
   localparam logic [2:0] OP_POP = 3'd3;
   localparam logic [2:0] OP_ISO = 3'd4;
   localparam logic [2:0] OP_CLR = 3'd5;

   logic             s1_valid_q, s1_valid_d;
   logic [2:0]       s1_op_q, s1_op_d;
   logic [WIDTH-1:0] s1_data_q, s1_data_d;
   logic [3:0]       s1_tag_q, s1_tag_d;
   logic             s2_valid_q, s2_valid_d;
   logic [WIDTH-1:0] s2_data_q, s2_data_d;
   logic [3:0]       s2_tag_q, s2_tag_d;
   logic             s2_flag_q, s2_flag_d;

   logic             adv2;
   logic [WIDTH-1:0] neg_x;
   logic [CNT_W-1:0] clz_cnt, ctz_cnt, pop_cnt;
   logic [WIDTH-1:0] res_data;
   logic             res_flag;
   logic             x_zero;

   assign adv2     = ~s2_valid_q | out_ready;
   assign in_ready = ~s1_valid_q | adv2;

   always_comb begin
      neg_x   = ~s1_data_q + ONE;
      x_zero  = (s1_data_q == '0);
      clz_cnt = CNT_W'(WIDTH);
      ctz_cnt = CNT_W'(WIDTH);
      pop_cnt = '0;
      // Ascending scan: the last hit is the highest set bit.
      for (int i = 0; i < WIDTH; i++) begin
         if (s1_data_q[i]) clz_cnt = CNT_W'(WIDTH - 1 - i);
         pop_cnt = pop_cnt + CNT_W'(s1_data_q[i]);
      end
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (s1_data_q[i]) ctz_cnt = CNT_W'(i);
      end

      res_data = '0;
      res_flag = 1'b0;
      case (s1_op_q)
         OP_ABS: begin
            res_data = s1_data_q[WIDTH-1] ? neg_x : s1_data_q;
            res_flag = (s1_data_q == MIN_NEG);
         end
         OP_CLZ: begin
            res_data = WIDTH'(clz_cnt);
            res_flag = x_zero;
         end
         OP_CTZ: begin
            res_data = WIDTH'(ctz_cnt);
            res_flag = x_zero;
         end
         OP_POP: res_data = WIDTH'(pop_cnt);
         OP_ISO: begin
            res_data = s1_data_q & neg_x;
            res_flag = x_zero;
         end
         OP_CLR: begin
            res_data = s1_data_q & (s1_data_q - ONE);
            res_flag = x_zero;
         end
         default: res_flag = 1'b1;
      endcase
   end

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_op_d    = s1_op_q;
      s1_data_d  = s1_data_q;
      s1_tag_d   = s1_tag_q;
      s2_valid_d = s2_valid_q;
      s2_data_d  = s2_data_q;
      s2_tag_d   = s2_tag_q;
      s2_flag_d  = s2_flag_q;

      if (in_ready) s1_valid_d = in_valid;
      if (in_valid && in_ready) begin
         s1_op_d   = in_op;
         s1_data_d = in_data;
         s1_tag_d  = in_tag;
      end

      if (adv2) s2_valid_d = s1_valid_q;
      if (s1_valid_q && adv2) begin
         s2_data_d = res_data;
         s2_tag_d  = s1_tag_q;
         s2_flag_d = res_flag;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_op_q    <= '0;
         s1_data_q  <= '0;
         s1_tag_q   <= '0;
         s2_valid_q <= 1'b0;
         s2_data_q  <= '0;
         s2_tag_q   <= '0;
         s2_flag_q  <= 1'b0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_op_q    <= s1_op_d;
         s1_data_q  <= s1_data_d;
         s1_tag_q   <= s1_tag_d;
         s2_valid_q <= s2_valid_d;
         s2_data_q  <= s2_data_d;
         s2_tag_q   <= s2_tag_d;
         s2_flag_q  <= s2_flag_d;
      end
   end

   assign out_valid = s2_valid_q;
   assign out_data  = s2_data_q;
   assign out_tag   = s2_tag_q;
   assign out_flag  = s2_flag_q;
   assign busy      = s1_valid_q | s2_valid_q;
endmodule

// File: tb/tb_hd_bitop_pipe.sv
// Directed bench for hd_bitop_pipe (WIDTH=32) with a queue scoreboard of expected results.
module tb_hd_bitop_pipe;
   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_op;
   logic [31:0] in_data;
   logic [3:0]  in_tag;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [3:0]  out_tag;
   logic        out_flag;
   logic        busy;

   hd_bitop_pipe #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_data(in_data), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_tag(out_tag), .out_flag(out_flag), .busy(busy)
   );

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  tag;
      logic        flag;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   run_len  = 0;
   int   max_run  = 0;
   logic        held_vld = 1'b0;
   logic [31:0] held_data;
   logic [3:0]  held_tag;
   logic        held_flag;
   exp_t        mon_e;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string nm, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
      end
   endtask

   function automatic logic [32:0] model(input logic [2:0] op, input logic [31:0] x);
      logic [31:0] r;
      logic        f;
      r = '0;
      f = 1'b0;
      case (op)
         3'd0: begin r = x[31] ? (32'd0 - x) : x; f = (x == 32'h8000_0000); end
         3'd1: begin
            r = 32;
            for (int i = 31; i >= 0; i--) if (x[i]) begin r = 31 - i; break; end
            f = (x == 0);
         end
         3'd2: begin
            r = 32;
            for (int i = 0; i < 32; i++) if (x[i]) begin r = i; break; end
            f = (x == 0);
         end
         3'd3: r = $countones(x);
         3'd4: begin r = x & (32'd0 - x); f = (x == 0); end
         3'd5: begin r = x & (x - 32'd1); f = (x == 0); end
         default: f = 1'b1;
      endcase
      return {f, r};
   endfunction

   // Drives one operand, waits (bounded) for acceptance, leaves in_valid high at posedge+1.
   task automatic send(input logic [2:0] op, input logic [31:0] d, input logic [3:0] tag,
                       input logic [31:0] ed, input logic ef, output int waited);
      exp_t e;
      in_valid = 1'b1;
      in_op    = op;
      in_data  = d;
      in_tag   = tag;
      waited   = 0;
      @(negedge clk);
      while (!in_ready && waited < 50) begin
         waited++;
         @(negedge clk);
      end
      if (!in_ready) check("accept_timeout", in_ready, 1'b1);
      else begin
         e.data = ed;
         e.tag  = tag;
         e.flag = ef;
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send_m(input logic [2:0] op, input logic [31:0] d, input logic [3:0] tag,
                         output int waited);
      logic [32:0] r;
      r = model(op, d);
      send(op, d, tag, r[31:0], r[32], waited);
   endtask

   task automatic drain();
      int w;
      in_valid = 1'b0;
      w = 0;
      while (sb.size() != 0 && w < 100) begin
         w++;
         @(negedge clk);
      end
      check("drain_empty", sb.size(), 0);
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (rst) begin
         sb.delete();
         held_vld = 1'b0;
         run_len  = 0;
      end else begin
         if (out_valid && !out_ready) begin
            if (held_vld) begin
               check("stall_data", out_data, held_data);
               check("stall_tag", out_tag, held_tag);
               check("stall_flag", out_flag, held_flag);
            end
            held_vld  = 1'b1;
            held_data = out_data;
            held_tag  = out_tag;
            held_flag = out_flag;
         end else begin
            held_vld = 1'b0;
         end
         if (out_valid && out_ready) begin
            run_len++;
            if (run_len > max_run) max_run = run_len;
            if (sb.size() == 0) check("unexpected_out", out_valid, 1'b0);
            else begin
               mon_e = sb.pop_front();
               check("out_data", out_data, mon_e.data);
               check("out_tag", out_tag, mon_e.tag);
               check("out_flag", out_flag, mon_e.flag);
            end
         end else begin
            run_len = 0;
         end
      end
   end

   initial begin
      int w;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_op     = '0;
      in_data   = '0;
      in_tag    = '0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_out_data", out_data, 32'h0);
      check("rst_out_tag", out_tag, 4'h0);
      check("rst_out_flag", out_flag, 1'b0);

      // Latency: POP 0xF0F0_0001 -> 9
      send(3'd3, 32'hF0F0_0001, 4'd3, 32'd9, 1'b0, w);
      in_valid = 1'b0;
      check("lat_early_valid", out_valid, 1'b0);
      check("lat_busy", busy, 1'b1);
      @(posedge clk);
      #1;
      check("lat_valid", out_valid, 1'b1);
      check("lat_data", out_data, 32'd9);
      check("lat_tag", out_tag, 4'd3);
      check("lat_flag", out_flag, 1'b0);
      drain();

      // Count edge cases
      send(3'd1, 32'h0000_0001, 4'd1, 32'd31, 1'b0, w);
      send(3'd1, 32'h0000_0000, 4'd2, 32'd32, 1'b1, w);
      send(3'd2, 32'h8000_0000, 4'd3, 32'd31, 1'b0, w);
      send(3'd2, 32'h0000_0000, 4'd4, 32'd32, 1'b1, w);
      drain();

      // ABS, ISO, CLR, reserved
      send(3'd0, 32'hFFFF_FFFB, 4'd5, 32'd5, 1'b0, w);
      send(3'd0, 32'h8000_0000, 4'd6, 32'h8000_0000, 1'b1, w);
      send(3'd4, 32'h0000_0068, 4'd7, 32'h8, 1'b0, w);
      send(3'd5, 32'h0000_0068, 4'd8, 32'h60, 1'b0, w);
      send(3'd4, 32'h0000_0000, 4'd9, 32'h0, 1'b1, w);
      send(3'd7, 32'h1234_5678, 4'd10, 32'h0, 1'b1, w);
      drain();

      // Backpressure
      out_ready = 1'b0;
      send_m(3'd3, 32'h0000_000F, 4'd0, w);
      send_m(3'd3, 32'h00FF_0000, 4'd1, w);
      in_op   = 3'd3;
      in_data = 32'hFFFF_FFFF;
      in_tag  = 4'd2;
      check("bp_in_ready_low", in_ready, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      check("bp_in_ready_held", in_ready, 1'b0);
      out_ready = 1'b1;
      send_m(3'd3, 32'hFFFF_FFFF, 4'd2, w);
      send_m(3'd3, 32'h8000_0001, 4'd3, w);
      drain();

      // Full throughput
      max_run = 0;
      for (int i = 0; i < 16; i++) begin
         send_m(3'($urandom_range(0, 7)), $urandom, 4'(i), w);
         check("tp_no_wait", w, 0);
      end
      drain();
      check("tp_run_len", (max_run >= 16), 1'b1);

      // Reset mid-operation
      out_ready = 1'b0;
      send_m(3'd3, 32'h1, 4'd11, w);
      send_m(3'd3, 32'h3, 4'd12, w);
      in_valid = 1'b0;
      check("mid_busy_full", busy, 1'b1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("mid_out_valid", out_valid, 1'b0);
      check("mid_busy", busy, 1'b0);
      check("mid_in_ready", in_ready, 1'b1);
      out_ready = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      check("mid_no_stale", out_valid, 1'b0);
      check("final_sb_empty", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
endmodule

// File: doc/hd_bitop_pipe.md
Name: hd_bitop_pipe

Overview:
- Parametrised, pipelined successor to the single-function combinational bit-manipulation benchmark blocks.
- One registered datapath provides six opcodes:
  - absolute value
  - count leading zeros
  - count trailing zeros
  - population count
  - isolate rightmost one
  - clear rightmost one
- Operand width is configurable.
- Uses valid/ready handshakes on input and output with full backpressure.
- Sits between an operand source and a result sink in the bit-manipulation benchmark harness.

Parameters:
- WIDTH, 32, operand and result width in bits; minimum 2, maximum 64.
- CNT_W, $clog2(WIDTH+1), width of the count results (derived, not overridable).

Ports:
- clk  in  1  clock; everything is updated on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand presented.
- in_ready  out  1  block accepts the operand this cycle.
- in_op  in  3  opcode: 0 ABS, 1 CLZ, 2 CTZ, 3 POP, 4 ISO (x & -x), 5 CLR (x & (x-1)), 6–7 reserved.
- in_data  in  WIDTH  operand, two's complement for ABS.
- in_tag  in  4  opaque ID, returned unchanged with the result.
- out_valid  out  1  result presented.
- out_ready  in  1  sink accepts the result.
- out_data  out  WIDTH  result; count ops are zero-extended from CNT_W.
- out_tag  out  4  tag of the presented result.
- out_flag  out  1  exception flag; see Behaviour.
- busy  out  1  high when any pipeline stage holds a valid entry.

Behaviour:
- Clock and reset:
  - One clock.
  - Reset is synchronous and active-high. On rst=1 at a rising edge, both stage valid bits clear; out_valid=0, busy=0, out_data=0, out_tag=0, out_flag=0.
  - A transaction in flight is discarded. in_ready reads 1 in the first cycle after reset.
- Pipeline structure:
  - S1 registers op, data and tag.
  - S2 holds the computed result, tag and flag, and drives the out_* ports directly from registers.
  - Latency is 2 cycles: an operand accepted at edge N has out_valid=1 after edge N+1 when there is no backpressure.
  - Sustained throughput is 1 operation per cycle.
- Handshake rules:
  - Input transfer when in_valid & in_ready.
  - Output transfer when out_valid & out_ready.
  - adv2 = ~s2_valid | out_ready.
  - in_ready = ~s1_valid | adv2. This is combinational from out_ready; there is no combinational path from in_valid to in_ready.
  - S1 moves to S2 when s1_valid & adv2.
  - When a stage is not advancing, its contents stay stable.
  - out_data, out_tag and out_flag stay constant while out_valid=1 & out_ready=0.
  - in_data is ignored when in_valid=0.
- Simultaneous events:
  - Accept, advance and drain in the same cycle are legal. With both stages full and out_ready=1, a new operand is accepted with no bubble.
  - rst has priority over every transfer.
- Arithmetic (computed combinationally between S1 and S2):
  - ABS: result = x if x[MSB]=0, else (~x + 1) modulo 2^WIDTH.
    - x = most-negative value (only the MSB set) returns itself with out_flag=1.
  - CLZ: number of zero bits above the highest one. x=0 gives WIDTH with out_flag=1.
  - CTZ: number of zero bits below the lowest one. x=0 gives WIDTH with out_flag=1.
  - POP: number of ones, from 0 to WIDTH inclusive; out_flag=0.
  - ISO: x & (~x + 1). x=0 gives 0 with out_flag=1.
  - CLR: x & (x − 1) modulo 2^WIDTH. x=0 gives 0 with out_flag=1.
  - Reserved opcodes 6–7: result 0 with out_flag=1. The tag is still returned and the pipeline does not stall.
  - In all other cases out_flag=0.
- busy = s1_valid | s2_valid.

Test Plan:
- Reset and latency (WIDTH=32):
  - Stimulus: assert rst for 2 cycles, then drive in_valid=1, op=POP, data=0xF0F0_0001, tag=3, with out_ready held at 1.
  - Required: out_valid first rises 2 edges after acceptance, with out_data=9, out_tag=3, out_flag=0.
- Count edge cases:
  - Stimulus: CLZ 0x0000_0001, CLZ 0x0000_0000, CTZ 0x8000_0000, CTZ 0.
  - Required: results 31/0, 32/1, 31/0, 32/1 (data/flag).
- ABS and ISO/CLR:
  - Stimulus: ABS 0xFFFF_FFFB, ABS 0x8000_0000, ISO 0x0000_0068, CLR 0x0000_0068, ISO 0, opcode 7.
  - Required: 5/0, 0x8000_0000/1, 0x8/0, 0x60/0, 0/1, 0/1 (data/flag).
- Backpressure:
  - Stimulus: stream 4 POP ops with tags 0–3 while out_ready=0 for 5 cycles, then raise out_ready.
  - Required: in_ready drops after 2 accepts; out_data/out_tag stay stable while stalled; all 4 results emerge in order with no loss or duplication.
- Full throughput:
  - Stimulus: 16 back-to-back ops with in_valid=1 and out_ready=1 throughout.
  - Required: in_ready stays at 1 and 16 consecutive out_valid cycles occur, with tags in order.
- Reset mid-operation:
  - Stimulus: fill both stages, then assert rst for 1 cycle.
  - Required: in the next cycle out_valid=0, busy=0, in_ready=1, and no stale result is emitted afterwards.
